shift_tx8b: RTL

SHIFT_TX8B -- requirements
Module: shift_tx8b

---
 rtl/shift_tx8b.sv | 116 +++++++++++
 1 files changed

// File: rtl/shift_tx8b.sv
`default_nettype none
// ============================================================================
//  Module      : shift_tx8b
//  Description : 8-bit parallel-to-serial transmitter with ready/valid load,
//                s_en bit pacing, back-to-back frame chaining and a one-cycle
//                done pulse after each completed frame.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MSB_FIRST   1 = bit 7 leaves first, 0 = bit 0 leaves first
//    IDLE_LEVEL  level driven on s_out while no frame is active
//  Ports
//    clk         clock, rising-edge active
//    rst_n       asynchronous active-low reset
//    p_in        parallel word to transmit
//    load_valid  p_in holds a word to send
//    load_ready  word on p_in is accepted this cycle
//    s_en        shift enable; 0 holds the current bit
//    s_out       serial data out
//    s_valid     s_out carries a frame bit
//    busy        frame in progress (same as s_valid)
//    done        one-cycle pulse after the last bit of a frame
// ============================================================================
module shift_tx8b #(
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] p_in,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic       s_en,
  output logic       s_out,
  output logic       s_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;
  logic [7:0] shreg_shift;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       done_r;
  logic       done_nxt;
  logic       last_bit;
  logic       accept;

  // Last bit is leaving on this edge; a new word may be taken in its place.
  assign last_bit   = (state == SHIFT) && s_en && (cnt == 3'd7);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // Shift toward the output end with zero fill.
  assign shreg_shift = (MSB_FIRST != 0) ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};

  assign s_valid = (state == SHIFT);
  assign busy    = s_valid;
  assign s_out   = (state == SHIFT) ? ((MSB_FIRST != 0) ? shreg[7] : shreg[0])
                                    : IDLE_LEVEL;
  assign done    = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= 8'h00;
      cnt    <= 3'd0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // s_en has no effect while idle
      end
      SHIFT: begin
        if (s_en) begin
          shreg_nxt = shreg_shift;
          cnt_nxt   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A load overrides the above; on the last-bit edge this chains the next
    // frame with no idle gap while done still reports the finished one.
    if (accept) begin
      state_nxt = SHIFT;
      shreg_nxt = p_in;
      cnt_nxt   = 3'd0;
    end
  end

endmodule
`default_nettype wire
